spi_frame_receiver: RTL and testbench

SPI-slave front end that receives one camera frame of 8-bit pixels (SPI mode 0, MSB first) and writes it into the CNN input frame buffer through a simple write port. It produces the frame-start and frame-complete status levels consumed by the CNN control logic. It holds the completed frame until that logic acknowledges it, and it flags short, overlong and overrun frames in sticky error bits.

---
 rtl/spi_frame_receiver.sv | 195 +++++++++++++++++++
 tb/tb_spi_frame_receiver.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_receiver.sv
// SPI mode-0 slave that captures one camera frame of 8-bit pixels into the
// CNN frame buffer and reports frame status plus sticky framing errors.
module spi_frame_receiver #(
  parameter int FRAME_PIXELS = 1024,
  parameter int ADDR_WIDTH   = 10,
  parameter int SYNC_STAGES  = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  spi_sclk,
  input  logic                  spi_cs_n,
  input  logic                  spi_mosi,
  input  logic                  frame_ack,
  input  logic                  err_clear,
  output logic                  buf_wr_en,
  output logic [ADDR_WIDTH-1:0] buf_wr_addr,
  output logic [7:0]            buf_wr_data,
  output logic                  frame_start,
  output logic                  frame_complete,
  output logic [ADDR_WIDTH:0]   pixel_count,
  output logic                  err_short,
  output logic                  err_overflow,
  output logic                  err_overrun
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    RECEIVE  = 2'd1,
    COMPLETE = 2'd2
  } state_e;

  localparam logic [ADDR_WIDTH:0] FRAME_CNT = (ADDR_WIDTH + 1)'(FRAME_PIXELS);

  // Synchronizers; chip select idles high so it resets high, avoiding a
  // false falling edge when reset is released.
  logic [SYNC_STAGES-1:0] sclk_sync_q, cs_sync_q, mosi_sync_q;
  logic                   sclk_prev_q, cs_prev_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync_q <= '0;
      cs_sync_q   <= '1;
      mosi_sync_q <= '0;
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments here so every flop samples the
      // pre-edge value of its neighbour; blocking would collapse the chain.
      sclk_sync_q <= {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], spi_cs_n};
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], spi_mosi};
      sclk_prev_q <= sclk_sync_q[SYNC_STAGES-1];
      cs_prev_q   <= cs_sync_q[SYNC_STAGES-1];
    end
  end

  logic sclk_s, cs_s, mosi_s;
  logic sclk_rise, cs_fall, cs_rise;

  assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
  assign cs_s      = cs_sync_q[SYNC_STAGES-1];
  assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_prev_q;
  assign cs_fall   = ~cs_s & cs_prev_q;
  assign cs_rise   = cs_s & ~cs_prev_q;

  state_e                state_q, state_d;
  logic [7:0]            shift_q, shift_d;
  logic [2:0]            bit_cnt_q, bit_cnt_d;
  logic [ADDR_WIDTH:0]   pixel_count_q, pixel_count_d;
  logic                  wr_en_q, wr_en_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]            wr_data_q, wr_data_d;
  logic                  frame_start_q, frame_start_d;
  logic                  frame_complete_q, frame_complete_d;
  logic                  err_short_q, err_short_d;
  logic                  err_overflow_q, err_overflow_d;
  logic                  err_overrun_q, err_overrun_d;
  logic                  set_short, set_overflow, set_overrun;
  logic [7:0]            byte_w;

  assign byte_w = {shift_q[6:0], mosi_s};

  always_comb begin
    // NOTE: every signal assigned below gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    state_d          = state_q;
    shift_d          = shift_q;
    bit_cnt_d        = bit_cnt_q;
    pixel_count_d    = pixel_count_q;
    wr_en_d          = 1'b0;
    wr_addr_d        = wr_addr_q;
    wr_data_d        = wr_data_q;
    frame_start_d    = frame_start_q;
    frame_complete_d = frame_complete_q;
    set_short        = 1'b0;
    set_overflow     = 1'b0;
    set_overrun      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (cs_fall) begin
          bit_cnt_d     = '0;
          shift_d       = '0;
          pixel_count_d = '0;
          frame_start_d = 1'b1;
          state_d       = RECEIVE;
        end
      end
      RECEIVE: begin
        // SCLK is at most clk/8, so a CS rise never shares a cycle with the
        // write launched by the final SCLK edge.
        if (cs_rise) begin
          frame_start_d = 1'b0;
          bit_cnt_d     = '0;
          if (pixel_count_q == FRAME_CNT) begin
            frame_complete_d = 1'b1;
            state_d          = COMPLETE;
          end else begin
            set_short = 1'b1;
            state_d   = IDLE;
          end
        end else if (sclk_rise) begin
          shift_d   = byte_w;
          bit_cnt_d = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            if (pixel_count_q < FRAME_CNT) begin
              wr_en_d       = 1'b1;
              wr_addr_d     = pixel_count_q[ADDR_WIDTH-1:0];
              wr_data_d     = byte_w;
              pixel_count_d = pixel_count_q + 1'b1;
            end else begin
              set_overflow = 1'b1;
            end
          end
        end
      end
      COMPLETE: begin
        // A frame started here is ignored; after an ack IDLE only reacts to
        // a fresh CS fall, so the rest of that frame is dropped as well.
        if (cs_fall) set_overrun = 1'b1;
        if (frame_ack) begin
          frame_complete_d = 1'b0;
          state_d          = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    err_short_d    = (err_short_q    & ~err_clear) | set_short;
    err_overflow_d = (err_overflow_q & ~err_clear) | set_overflow;
    err_overrun_d  = (err_overrun_q  & ~err_clear) | set_overrun;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q          <= IDLE;
      shift_q          <= '0;
      bit_cnt_q        <= '0;
      pixel_count_q    <= '0;
      wr_en_q          <= 1'b0;
      wr_addr_q        <= '0;
      wr_data_q        <= '0;
      frame_start_q    <= 1'b0;
      frame_complete_q <= 1'b0;
      err_short_q      <= 1'b0;
      err_overflow_q   <= 1'b0;
      err_overrun_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      shift_q          <= shift_d;
      bit_cnt_q        <= bit_cnt_d;
      pixel_count_q    <= pixel_count_d;
      wr_en_q          <= wr_en_d;
      wr_addr_q        <= wr_addr_d;
      wr_data_q        <= wr_data_d;
      frame_start_q    <= frame_start_d;
      frame_complete_q <= frame_complete_d;
      err_short_q      <= err_short_d;
      err_overflow_q   <= err_overflow_d;
      err_overrun_q    <= err_overrun_d;
    end
  end

  assign buf_wr_en      = wr_en_q;
  assign buf_wr_addr    = wr_addr_q;
  assign buf_wr_data    = wr_data_q;
  assign frame_start    = frame_start_q;
  assign frame_complete = frame_complete_q;
  assign pixel_count    = pixel_count_q;
  assign err_short      = err_short_q;
  assign err_overflow   = err_overflow_q;
  assign err_overrun    = err_overrun_q;

endmodule

// File: tb/tb_spi_frame_receiver.sv
// Self-checking bench for spi_frame_receiver: randomized SPI frames compared
// against a frame-level model of expected buffer writes and status bits.
module tb_spi_frame_receiver;

  localparam int F  = 24;
  localparam int AW = 5;
  localparam int SW = AW + 6;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          spi_sclk = 1'b0;
  logic          spi_cs_n = 1'b1;
  logic          spi_mosi = 1'b0;
  logic          frame_ack = 1'b0;
  logic          err_clear = 1'b0;
  logic          buf_wr_en;
  logic [AW-1:0] buf_wr_addr;
  logic [7:0]    buf_wr_data;
  logic          frame_start;
  logic          frame_complete;
  logic [AW:0]   pixel_count;
  logic          err_short;
  logic          err_overflow;
  logic          err_overrun;

  spi_frame_receiver #(.FRAME_PIXELS(F), .ADDR_WIDTH(AW), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst_n(rst_n), .spi_sclk(spi_sclk), .spi_cs_n(spi_cs_n),
    .spi_mosi(spi_mosi), .frame_ack(frame_ack), .err_clear(err_clear),
    .buf_wr_en(buf_wr_en), .buf_wr_addr(buf_wr_addr), .buf_wr_data(buf_wr_data),
    .frame_start(frame_start), .frame_complete(frame_complete),
    .pixel_count(pixel_count), .err_short(err_short),
    .err_overflow(err_overflow), .err_overrun(err_overrun)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } wr_t;

  wr_t got_wr[$];
  wr_t exp_wr[$];
  int  checks = 0;
  int  fails = 0;
  int  dbl_cnt = 0;
  logic prev_wr_en = 1'b0;

  bit  exp_complete, exp_short, exp_overflow, exp_overrun;
  int  exp_pix;
  logic fs_mid;

  // Write monitor samples on the falling edge, away from DUT updates.
  always @(negedge clk) begin
    if (buf_wr_en) got_wr.push_back('{addr: buf_wr_addr, data: buf_wr_data});
    if (buf_wr_en && prev_wr_en) dbl_cnt++;
    prev_wr_en = buf_wr_en;
  end

  function automatic logic [SW-1:0] got_status();
    return {frame_start, frame_complete, err_short, err_overflow, err_overrun, pixel_count};
  endfunction

  function automatic logic [SW-1:0] exp_status();
    return {1'b0, exp_complete, exp_short, exp_overflow, exp_overrun, (AW + 1)'(exp_pix)};
  endfunction

  function automatic int wr_mismatch();
    if (got_wr.size() != exp_wr.size()) return -2;
    foreach (exp_wr[i]) if (got_wr[i] !== exp_wr[i]) return i;
    return -1;
  endfunction

  task automatic send_bits(input logic [7:0] b, input int nbits, input int half);
    for (int i = 7; i > 7 - nbits; i--) begin
      spi_mosi = b[i];
      #(half) spi_sclk = 1'b1;
      #(half) spi_sclk = 1'b0;
    end
  endtask

  // Drives one CS assertion and advances the model by the frame-level rules.
  task automatic run_frame(input int nbytes, input int extra_bits, input bit ramp);
    logic [7:0] tx[$];
    int half;
    half = 10 * $urandom_range(4, 6);
    for (int i = 0; i < nbytes; i++) tx.push_back(ramp ? 8'(i) : 8'($urandom));
    if (exp_complete) begin
      exp_overrun = 1'b1;
    end else begin
      for (int i = 0; i < nbytes && i < F; i++)
        exp_wr.push_back('{addr: AW'(i), data: tx[i]});
      exp_pix = (nbytes < F) ? nbytes : F;
      if (nbytes < F) exp_short = 1'b1;
      else exp_complete = 1'b1;
      if (nbytes > F) exp_overflow = 1'b1;
    end
    fs_mid = 1'bx;
    spi_cs_n = 1'b0;
    #(2 * half);
    foreach (tx[i]) begin
      send_bits(tx[i], 8, half);
      if (i == 0) fs_mid = frame_start;
    end
    if (extra_bits > 0) send_bits(8'($urandom), extra_bits, half);
    #(half) spi_cs_n = 1'b1;
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int which);
    @(posedge clk) #1;
    if (which == 0) frame_ack = 1'b1; else err_clear = 1'b1;
    @(posedge clk) #1;
    frame_ack = 1'b0;
    err_clear = 1'b0;
    if (which == 0 && exp_complete) exp_complete = 1'b0;
    if (which == 1) {exp_short, exp_overflow, exp_overrun} = 3'b000;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic check_frame(input string name, input logic exp_fs);
    int m;
    m = wr_mismatch();
    checks++;
    if (m != -1) begin
      $display("FAIL %s writes: got %0d writes, expected %0d (first bad index %0d)",
               name, got_wr.size(), exp_wr.size(), m);
      fails++;
    end
    checks++;
    if (got_status() !== exp_status()) begin
      $display("FAIL %s status: got %b, expected %b", name, got_status(), exp_status());
      fails++;
    end
    checks++;
    if (fs_mid !== exp_fs) begin
      $display("FAIL %s frame_start mid-frame: got %b, expected %b", name, fs_mid, exp_fs);
      fails++;
    end
    got_wr.delete();
    exp_wr.delete();
  endtask

  task automatic test_reset();
    checks++;
    if ({buf_wr_en, buf_wr_addr, buf_wr_data, got_status()} !== '0) begin
      $display("FAIL reset outputs: got %b, expected all zero",
               {buf_wr_en, buf_wr_addr, buf_wr_data, got_status()});
      fails++;
    end
  endtask

  task automatic test_full_frame();
    run_frame(F, 0, 1'b1);
    check_frame("full_frame", 1'b1);
    checks++;
    if (dbl_cnt != 0) begin
      $display("FAIL write_pulse_width: got %0d multi-cycle strobes, expected 0", dbl_cnt);
      fails++;
    end
    pulse(0);
    checks++;
    if (got_status() !== exp_status()) begin
      $display("FAIL ack_release: got %b, expected %b", got_status(), exp_status());
      fails++;
    end
  endtask

  task automatic test_short_frame();
    run_frame(10, 0, 1'b0);
    check_frame("short_frame", 1'b1);
    run_frame(F, 0, 1'b0);
    check_frame("full_after_short", 1'b1);
    pulse(0);
  endtask

  task automatic test_overflow();
    run_frame(F + 6, 0, 1'b0);
    check_frame("overflow", 1'b1);
  endtask

  task automatic test_overrun();
    run_frame(5, 0, 1'b0);
    check_frame("overrun", 1'b0);
    pulse(0);
    checks++;
    if (got_status() !== exp_status()) begin
      $display("FAIL overrun_ack: got %b, expected %b", got_status(), exp_status());
      fails++;
    end
    pulse(0);
    checks++;
    if (got_status() !== exp_status()) begin
      $display("FAIL ack_in_idle: got %b, expected %b", got_status(), exp_status());
      fails++;
    end
    pulse(1);
    checks++;
    if (got_status() !== exp_status()) begin
      $display("FAIL err_clear: got %b, expected %b", got_status(), exp_status());
      fails++;
    end
  endtask

  task automatic test_partial_byte();
    run_frame(F, 3, 1'b0);
    check_frame("partial_byte", 1'b1);
    pulse(0);
  endtask

  task automatic test_reset_mid_frame();
    spi_cs_n = 1'b0;
    #100;
    for (int i = 0; i < 10; i++) send_bits(8'($urandom), 8, 50);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({buf_wr_en, buf_wr_addr, buf_wr_data, got_status()} !== '0) begin
      $display("FAIL reset_mid_frame outputs: got %b, expected all zero",
               {buf_wr_en, buf_wr_addr, buf_wr_data, got_status()});
      fails++;
    end
    spi_cs_n = 1'b1;
    #50 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    got_wr.delete();
    exp_wr.delete();
    {exp_complete, exp_short, exp_overflow, exp_overrun} = 4'b0000;
    exp_pix = 0;
    run_frame(F, 0, 1'b0);
    check_frame("after_reset", 1'b1);
  endtask

  initial begin
    {exp_complete, exp_short, exp_overflow, exp_overrun} = 4'b0000;
    exp_pix = 0;
    #2;
    test_reset();
    #50 rst_n = 1'b1;
    repeat (5) @(posedge clk);
    test_full_frame();
    test_short_frame();
    test_overflow();
    test_overrun();
    test_partial_byte();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
